dlx_pipe_ctrl: RTL and testbench
================================

Name: dlx_pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage DLX core (IF, ID, EX, MEM, WB). Sits beside the instruction decoder.
- Takes per-instruction register/class info from ID and resolution info from EX and MEM.
- Generates PC/IF-ID enables, squash and bubble controls, and operand forwarding selects.
- Tracks in-flight destination registers and keeps saturating stall and flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_AW  source register 1 of ID instruction.
- id_rs2  in  REG_AW  source register 2 of ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2 (0 for immediate forms).
- id_wr  in  1  ID instruction writes a register (regWr).
- id_wd  in  REG_AW  destination register of ID instruction (rD, rS2 or r31 already muxed).
- id_load  in  1  ID instruction is a load.
- ex_redirect  in  1  EX holds a taken beqz/bnez or any J/JAL/JR/JALR this cycle.
- mem_busy  in  1  data memory wait; whole pipe freezes.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loaded with NOP (0x00000015).
- idex_bubble  out  1  ID/EX loaded with NOP instead of ID instruction.
- fwd_a  out  2  rs1 operand select: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
- fwd_b  out  2  rs2 operand select, same encoding.
- ctrl_state  out  2  action taken last cycle: 00 RUN, 01 INTERLOCK, 10 REDIRECT, 11 FREEZE.
- stall_cnt  out  CNT_W  cycles spent in INTERLOCK or FREEZE, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.

Behaviour:
- Tracking registers are valid bit, wd, wr and load for each of the EX, MEM and WB slots.
- A slot matches register r when it is valid, its wr is 1, r != 0, wd == r, and the operand's use bit is 1.
- Action is combinational per cycle. Priority: FREEZE > REDIRECT > INTERLOCK > RUN.
  - FREEZE (mem_busy=1): pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0. Tracking registers hold.
  - REDIRECT (ex_redirect=1): pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1. Both the IF and ID instructions are squashed.
  - INTERLOCK (id_valid and either used source matches the EX slot with load=1): pc_en=0, ifid_en=0, idex_bubble=1. Exactly one bubble per load-use pair.
  - RUN: pc_en=1, ifid_en=1, flush=0, bubble=0.
- Forwarding select for each operand picks the youngest matching slot, checked in the order EX (01), MEM (10), WB (11); with no match, or r0, the select is 00.
  - The forwarding selects are meaningful only in RUN; they are still driven in all states.
  - A load in the MEM slot forwards as 10, since its data is valid at the end of MEM.
- Clock edge, when not FREEZE:
  - WB takes MEM; MEM takes EX.
  - EX takes the ID info if id_valid=1 and action is RUN. Otherwise EX becomes invalid (bubble or squash).
- ctrl_state registers the action taken.
- stall_cnt increments when the action is INTERLOCK or FREEZE. flush_cnt increments when the action is REDIRECT.
- Both counters saturate at all-ones; no wrap.
- Async reset (rst_n=0), taking effect immediately, even mid-stall or mid-redirect:
  - All tracking valid bits = 0, ctrl_state = 00, counters = 0.
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00 while rst_n=0.
- After reset release, the first edge behaves as RUN with empty tracking.
- A redirect coinciding with a load-use in ID is handled as REDIRECT only; no interlock is counted.
- The NOP encoding has id_wr=0, so it never creates a match.

Test Plan:
- Back-to-back ALU dependency: add r3←r1,r2 then sub r4←r3,r5 → second instruction sees fwd_a=01, RUN, stall_cnt stays 0.
- Load-use: lw r7 then add r8←r7,r7 → one cycle with INTERLOCK: pc_en=0, idex_bubble=1, fwd_a=fwd_b=01 ignored. Next cycle RUN with fwd_a=fwd_b=10; stall_cnt=1.
- Taken branch with load-use in ID at the same cycle: ex_redirect=1 → ifid_flush=1, idex_bubble=1, ctrl_state next=10, flush_cnt=1, stall_cnt unchanged.
- mem_busy held 3 cycles during a load-use pair → enables 0 for 3 cycles with tracking unchanged, then INTERLOCK once; stall_cnt=4.
- Writes to r0 (id_wd=0, id_wr=1) followed by a reader of r0 → fwd=00, no interlock, even if the writer was a load.
- Reset asserted mid-INTERLOCK → all outputs immediately 0; after release, a former EX load no longer matches; counters read 0. Preload stall_cnt to 0xFFFF and interlock → stays 0xFFFF.

Source files
------------

// File: rtl/dlx_pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage DLX core: freeze/redirect/interlock
// arbitration, operand forwarding selects, in-flight destination tracking and perf counters.
module dlx_pipe_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_wd,
  input  logic              id_load,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        ctrl_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] ST_RUN = 2'b00;
  localparam logic [1:0] ST_ILK = 2'b01;
  localparam logic [1:0] ST_RED = 2'b10;
  localparam logic [1:0] ST_FRZ = 2'b11;

  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  // r0 is hardwired to zero, so it never matches an in-flight writer.
  function automatic logic slot_match(input logic v, input logic wr, input logic [REG_AW-1:0] wd,
                                      input logic [REG_AW-1:0] r, input logic use_r);
    return v & wr & use_r & (r != REG_ZERO) & (wd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem, input logic m_wb);
    logic [1:0] sel;
    if (m_ex) begin
      sel = 2'b01;
    end else if (m_mem) begin
      sel = 2'b10;
    end else if (m_wb) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  logic              ex_v_r, mem_v_r, wb_v_r;
  logic              ex_wr_r, mem_wr_r, wb_wr_r;
  logic              ex_ld_r, mem_ld_r, wb_ld_r;
  logic [REG_AW-1:0] ex_wd_r, mem_wd_r, wb_wd_r;
  logic [1:0]        ctrl_state_r;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;

  logic a_ex_s, a_mem_s, a_wb_s, b_ex_s, b_mem_s, b_wb_s;
  logic ilk_s;
  logic [1:0] action_s;

  assign a_ex_s  = slot_match(ex_v_r,  ex_wr_r,  ex_wd_r,  id_rs1, id_use_rs1);
  assign a_mem_s = slot_match(mem_v_r, mem_wr_r, mem_wd_r, id_rs1, id_use_rs1);
  assign a_wb_s  = slot_match(wb_v_r,  wb_wr_r,  wb_wd_r,  id_rs1, id_use_rs1);
  assign b_ex_s  = slot_match(ex_v_r,  ex_wr_r,  ex_wd_r,  id_rs2, id_use_rs2);
  assign b_mem_s = slot_match(mem_v_r, mem_wr_r, mem_wd_r, id_rs2, id_use_rs2);
  assign b_wb_s  = slot_match(wb_v_r,  wb_wr_r,  wb_wd_r,  id_rs2, id_use_rs2);
  assign ilk_s   = id_valid & ex_ld_r & (a_ex_s | b_ex_s);

  // Action arbitration: FREEZE > REDIRECT > INTERLOCK > RUN.
  always_comb begin
    action_s = ST_RUN;
    if (mem_busy) begin
      action_s = ST_FRZ;
    end else if (ex_redirect) begin
      action_s = ST_RED;
    end else if (ilk_s) begin
      action_s = ST_ILK;
    end else begin
      action_s = ST_RUN;
    end
  end

  // Pipeline control outputs, forced inactive while reset is held.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (!rst_n) begin
      pc_en = 1'b0;
    end else begin
      fwd_a = fwd_sel(a_ex_s, a_mem_s, a_wb_s);
      fwd_b = fwd_sel(b_ex_s, b_mem_s, b_wb_s);
      case (action_s)
        ST_RUN: begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
        ST_ILK: idex_bubble = 1'b1;
        ST_RED: begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        ST_FRZ:  pc_en = 1'b0;
        default: pc_en = 1'b0;
      endcase
    end
  end

  // Slot tracking, registered action and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_r <= 1'b0; mem_v_r <= 1'b0; wb_v_r <= 1'b0;
      ex_wr_r <= 1'b0; mem_wr_r <= 1'b0; wb_wr_r <= 1'b0;
      ex_ld_r <= 1'b0; mem_ld_r <= 1'b0; wb_ld_r <= 1'b0;
      ex_wd_r <= REG_ZERO; mem_wd_r <= REG_ZERO; wb_wd_r <= REG_ZERO;
      ctrl_state_r <= ST_RUN;
      stall_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      ctrl_state_r <= action_s;
      if (((action_s == ST_ILK) || (action_s == ST_FRZ)) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if ((action_s == ST_RED) && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
      if (action_s != ST_FRZ) begin
        wb_v_r  <= mem_v_r;  wb_wr_r  <= mem_wr_r;  wb_ld_r  <= mem_ld_r;  wb_wd_r  <= mem_wd_r;
        mem_v_r <= ex_v_r;   mem_wr_r <= ex_wr_r;   mem_ld_r <= ex_ld_r;   mem_wd_r <= ex_wd_r;
        ex_v_r  <= id_valid & (action_s == ST_RUN);
        ex_wr_r <= id_wr;
        ex_ld_r <= id_load;
        ex_wd_r <= id_wd;
      end
    end
  end

  assign ctrl_state = ctrl_state_r;
  assign stall_cnt  = stall_cnt_r;
  assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Self-checking bench for dlx_pipe_ctrl: vector table with a ctrl_state scoreboard queue,
// plus hand sequences for mid-stall reset and counter saturation on a narrow-counter instance.
module tb_dlx_pipe_ctrl;

  typedef struct {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2; logic wr; logic [4:0] wd;
    logic ld; logic rd; logic bz;
    logic pc; logic ifd; logic fl; logic bb; logic [1:0] fa; logic [1:0] fb; logic [1:0] st;
    int sc; int fc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs1, id_use_rs2, id_wr, id_load, ex_redirect, mem_busy;
  logic [4:0] id_rs1, id_rs2, id_wd;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b, ctrl_state;
  logic [15:0] stall_cnt, flush_cnt;

  logic       s_valid, s_u1, s_u2, s_wr, s_ld, s_redir, s_busy;
  logic [4:0] s_rs1, s_rs2, s_wd;
  logic       s_pc_en, s_ifid_en, s_flush, s_bubble;
  logic [1:0] s_fa, s_fb, s_state;
  logic [3:0] s_stall, s_flcnt;

  dlx_pipe_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr(id_wr), .id_wd(id_wd),
    .id_load(id_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  dlx_pipe_ctrl #(.REG_AW(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(s_valid), .id_rs1(s_rs1), .id_rs2(s_rs2),
    .id_use_rs1(s_u1), .id_use_rs2(s_u2), .id_wr(s_wr), .id_wd(s_wd),
    .id_load(s_ld), .ex_redirect(s_redir), .mem_busy(s_busy), .pc_en(s_pc_en),
    .ifid_en(s_ifid_en), .ifid_flush(s_flush), .idex_bubble(s_bubble), .fwd_a(s_fa),
    .fwd_b(s_fb), .ctrl_state(s_state), .stall_cnt(s_stall), .flush_cnt(s_flcnt));

  int checks = 0;
  int errors = 0;
  logic [1:0] st_q[$];
  vec_t vecs[20];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, rs1, rs2, u1, u2, wr, wd, ld, rd, bz,
                              pc, ifd, fl, bb, fa, fb, st, sc, fc);
    vec_t t;
    t.v = v[0]; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.u1 = u1[0]; t.u2 = u2[0];
    t.wr = wr[0]; t.wd = wd[4:0]; t.ld = ld[0]; t.rd = rd[0]; t.bz = bz[0];
    t.pc = pc[0]; t.ifd = ifd[0]; t.fl = fl[0]; t.bb = bb[0];
    t.fa = fa[1:0]; t.fb = fb[1:0]; t.st = st[1:0]; t.sc = sc; t.fc = fc;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    id_wr = t.wr; id_wd = t.wd; id_load = t.ld; ex_redirect = t.rd; mem_busy = t.bz;
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [1:0] exp_st;
    drive(t);
    @(negedge clk);
    chk($sformatf("v%0d.pc_en", idx), int'(pc_en), int'(t.pc));
    chk($sformatf("v%0d.ifid_en", idx), int'(ifid_en), int'(t.ifd));
    chk($sformatf("v%0d.ifid_flush", idx), int'(ifid_flush), int'(t.fl));
    chk($sformatf("v%0d.idex_bubble", idx), int'(idex_bubble), int'(t.bb));
    chk($sformatf("v%0d.fwd_a", idx), int'(fwd_a), int'(t.fa));
    chk($sformatf("v%0d.fwd_b", idx), int'(fwd_b), int'(t.fb));
    st_q.push_back(t.st);
    @(posedge clk);
    #1;
    exp_st = st_q.pop_front();
    chk($sformatf("v%0d.ctrl_state", idx), int'(ctrl_state), int'(exp_st));
    chk($sformatf("v%0d.stall_cnt", idx), int'(stall_cnt), t.sc);
    chk($sformatf("v%0d.flush_cnt", idx), int'(flush_cnt), t.fc);
  endtask

  initial begin
    //           v rs1 rs2 u1 u2 wr wd ld rd bz   pc if fl bb fa fb st  sc fc
    vecs[0]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  0, 0); // add r3<-r1,r2
    vecs[1]  = mk(1, 3, 5, 1, 1, 1, 4, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0,  0, 0); // sub r4<-r3,r5
    vecs[2]  = mk(1, 3, 4, 1, 1, 1, 6, 0, 0, 0,  1, 1, 0, 0, 2, 1, 0,  0, 0);
    vecs[3]  = mk(1, 3, 3, 1, 1, 1, 9, 0, 0, 0,  1, 1, 0, 0, 3, 3, 0,  0, 0);
    vecs[4]  = mk(1, 0, 4, 1, 0, 1, 7, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0,  0, 0); // lw r7
    vecs[5]  = mk(1, 7, 7, 1, 1, 1, 8, 0, 0, 0,  0, 0, 0, 1, 1, 1, 1,  1, 0); // load-use
    vecs[6]  = mk(1, 7, 7, 1, 1, 1, 8, 0, 0, 0,  1, 1, 0, 0, 2, 2, 0,  1, 0);
    vecs[7]  = mk(1, 0, 0, 1, 0, 1,10, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 0); // lw r10
    vecs[8]  = mk(1,10, 1, 1, 1, 1,11, 0, 1, 0,  1, 1, 1, 1, 1, 0, 2,  1, 1); // redirect + load-use
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1);
    vecs[10] = mk(1, 0, 0, 1, 0, 1,12, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1); // lw r12
    vecs[11] = mk(1,12, 2, 1, 1, 1,13, 0, 0, 1,  0, 0, 0, 0, 1, 0, 3,  2, 1); // frozen x3
    vecs[12] = mk(1,12, 2, 1, 1, 1,13, 0, 0, 1,  0, 0, 0, 0, 1, 0, 3,  3, 1);
    vecs[13] = mk(1,12, 2, 1, 1, 1,13, 0, 0, 1,  0, 0, 0, 0, 1, 0, 3,  4, 1);
    vecs[14] = mk(1,12, 2, 1, 1, 1,13, 0, 0, 0,  0, 0, 0, 1, 1, 0, 1,  5, 1);
    vecs[15] = mk(1,12, 2, 1, 1, 1,13, 0, 0, 0,  1, 1, 0, 0, 2, 0, 0,  5, 1);
    vecs[16] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0,  5, 1); // lw r0
    vecs[17] = mk(1, 0, 0, 1, 1, 1,14, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  5, 1); // reads r0
    vecs[18] = mk(1,13,14, 1, 1, 1,17, 0, 0, 0,  1, 1, 0, 0, 3, 1, 0,  5, 1);
    vecs[19] = mk(1, 0, 0, 1, 0, 1,15, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0,  5, 1); // lw r15

    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0));
    s_valid = 1'b0; s_rs1 = 5'd0; s_rs2 = 5'd0; s_u1 = 1'b0; s_u2 = 1'b0; s_wr = 1'b0;
    s_wd = 5'd0; s_ld = 1'b0; s_redir = 1'b0; s_busy = 1'b0;

    #2;
    chk("rst.pc_en", int'(pc_en), 0);
    chk("rst.ifid_en", int'(ifid_en), 0);
    chk("rst.ctrl_state", int'(ctrl_state), 0);
    chk("rst.stall_cnt", int'(stall_cnt), 0);
    chk("rst.flush_cnt", int'(flush_cnt), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) apply(vecs[i], i);

    // Freeze, then reset arrives in the middle of an interlock.
    apply(mk(1,15,15,1,1,1,16,0,0,1, 0,0,0,0,1,1,3, 6,1), 20);
    mem_busy = 1'b0;
    @(negedge clk);
    chk("ilk.pc_en", int'(pc_en), 0);
    chk("ilk.idex_bubble", int'(idex_bubble), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.pc_en", int'(pc_en), 0);
    chk("midrst.ifid_en", int'(ifid_en), 0);
    chk("midrst.ifid_flush", int'(ifid_flush), 0);
    chk("midrst.idex_bubble", int'(idex_bubble), 0);
    chk("midrst.fwd_a", int'(fwd_a), 0);
    chk("midrst.fwd_b", int'(fwd_b), 0);
    chk("midrst.ctrl_state", int'(ctrl_state), 0);
    chk("midrst.stall_cnt", int'(stall_cnt), 0);
    chk("midrst.flush_cnt", int'(flush_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post.pc_en", int'(pc_en), 1);
    chk("post.idex_bubble", int'(idex_bubble), 0);
    chk("post.fwd_a", int'(fwd_a), 0);
    chk("post.fwd_b", int'(fwd_b), 0);
    @(posedge clk);
    #1;
    chk("post.ctrl_state", int'(ctrl_state), 0);
    chk("post.stall_cnt", int'(stall_cnt), 0);
    chk("post.flush_cnt", int'(flush_cnt), 0);

    // Saturation on the 4-bit counter instance.
    s_busy = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sat.stall_full", int'(s_stall), 15);
    chk("sat.state_frz", int'(s_state), 3);
    s_busy = 1'b0;
    s_valid = 1'b1; s_u1 = 1'b1; s_rs1 = 5'd0; s_wr = 1'b1; s_wd = 5'd1; s_ld = 1'b1;
    @(posedge clk);
    #1;
    s_rs1 = 5'd1; s_wd = 5'd2; s_ld = 1'b0;
    @(negedge clk);
    chk("sat.ilk_bubble", int'(s_bubble), 1);
    @(posedge clk);
    #1;
    chk("sat.state_ilk", int'(s_state), 1);
    chk("sat.stall_hold", int'(s_stall), 15);
    s_redir = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sat.flush_full", int'(s_flcnt), 15);
    chk("sat.state_red", int'(s_state), 2);
    chk("sat.stall_after", int'(s_stall), 15);
    s_redir = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
